apb_master_bridge: RTL and testbench

// - APB requester (initiator) that converts a simple valid/ready command interface into APB4 transfers.
// - Drives the UART register-block APB port; used by the host/DMA side and as the bus driver for the UART subsystem bench.
// - One transfer is outstanding at a time. Each accepted command returns exactly one single-cycle response pulse.

---
 rtl/apb_master_bridge.sv | 158 +++++++++++++++
 tb/tb_apb_master_bridge.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - valid/ready command to APB4 requester, one transfer outstanding
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge #(
    parameter logic [11:0] ADDR_MIN       = 12'h000,
    parameter logic [11:0] ADDR_MAX       = 12'h010,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        i_pclk,
    input  logic        i_preset,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_write,
    input  logic [11:0] i_cmd_addr,
    input  logic [31:0] i_cmd_wdata,
    input  logic [3:0]  i_cmd_strb,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_rsp_timeout,
    output logic        o_psel,
    output logic        o_penable,
    output logic        o_pwrite,
    output logic [11:0] o_paddr,
    output logic [3:0]  o_pstrb,
    output logic [31:0] o_pwdata,
    input  logic [31:0] i_prdata,
    input  logic        i_pready,
    input  logic        i_pslverr
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

    localparam logic [11:0] ADDR_SPAN = ADDR_MAX - ADDR_MIN;

    state_t      r_state;
    state_t      w_next;
    logic        r_psel;
    logic        r_penable;
    logic        r_pwrite;
    logic [11:0] r_paddr;
    logic [3:0]  r_pstrb;
    logic [31:0] r_pwdata;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;

    logic        w_accept;
    logic        w_in_range;
    logic        w_done;
    logic        w_expire;
    logic [11:0] w_offset;

    // Wrapping subtraction folds both range bounds into one unsigned compare.
    assign w_offset    = i_cmd_addr - ADDR_MIN;
    assign w_in_range  = (w_offset <= ADDR_SPAN);
    assign w_accept    = i_cmd_valid && (r_state == S_IDLE);
    assign w_done      = (r_state == S_ACCESS) && i_pready;
    assign o_cmd_ready = (r_state == S_IDLE);

`ifdef APB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_to_cnt;
    logic       r_rsp_timeout;

    // A ready in the limit cycle completes normally, so expiry requires pready low.
    assign w_expire = (r_state == S_ACCESS) && !i_pready && (r_to_cnt == TO_LAST);

    always_ff @(posedge i_pclk) begin
        if (i_preset) begin
            r_to_cnt      <= 8'd0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_timeout <= w_expire;
            if (w_accept && w_in_range)
                r_to_cnt <= 8'd0;
            else if ((r_state == S_ACCESS) && !i_pready)
                r_to_cnt <= r_to_cnt + 8'd1;
        end
    end

    assign o_rsp_timeout = r_rsp_timeout;
`else
    assign w_expire      = 1'b0;
    assign o_rsp_timeout = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = w_in_range ? S_SETUP : S_RESP;
            S_SETUP:  w_next = S_ACCESS;
            S_ACCESS: if (w_done || w_expire) w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_pclk) begin
        if (i_preset) begin
            r_state     <= S_IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= 12'd0;
            r_pstrb     <= 4'd0;
            r_pwdata    <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_in_range) begin
                        r_psel   <= 1'b1;
                        r_pwrite <= i_cmd_write;
                        r_paddr  <= i_cmd_addr;
                        r_pstrb  <= i_cmd_write ? i_cmd_strb : 4'd0;
                        r_pwdata <= i_cmd_write ? i_cmd_wdata : 32'd0;
                    end else if (w_accept) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                    end
                end
                S_SETUP: r_penable <= 1'b1;
                S_ACCESS: begin
                    if (w_done || w_expire) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_pwrite    <= 1'b0;
                        r_paddr     <= 12'd0;
                        r_pstrb     <= 4'd0;
                        r_pwdata    <= 32'd0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_expire || i_pslverr;
                        r_rsp_rdata <= (w_done && !r_pwrite && !i_pslverr) ? i_prdata : 32'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_psel      = r_psel;
    assign o_penable   = r_penable;
    assign o_pwrite    = r_pwrite;
    assign o_paddr     = r_paddr;
    assign o_pstrb     = r_pstrb;
    assign o_pwdata    = r_pwdata;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - randomized self-checking bench for apb_master_bridge
module tb_apb_master_bridge;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        preset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [3:0]  pstrb;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    apb_master_bridge dut (
        .i_pclk(clk), .i_preset(preset),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
        .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_strb(cmd_strb),
        .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
        .o_rsp_timeout(rsp_timeout),
        .o_psel(psel), .o_penable(penable), .o_pwrite(pwrite), .o_paddr(paddr),
        .o_pstrb(pstrb), .o_pwdata(pwdata),
        .i_prdata(prdata), .i_pready(pready), .i_pslverr(pslverr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one command from IDLE; acts as a simple APB completer that raises pready
    // after `waits` ACCESS cycles. Returns at posedge+1 once the bridge is back in IDLE.
    task automatic do_cmd(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int waits, input logic slverr,
                          input logic [31:0] rdata);
        int          a = int'(addr);
        bit          in_rng = (a >= 0) && (a <= 16);
        bit          tmo = 1'b0;
        int          exp_acc, exp_psel, exp_k;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [48:0] exp_bus;
        int          psel_n = 0, pen_n = 0, acc_idx = 0, rsp_n = 0, rsp_k = -1;
        logic [31:0] got_rdata = 32'd0;
        logic        got_err = 1'b0, got_to = 1'b0;
`ifdef APB_TIMEOUT_EN
        tmo = in_rng && (waits >= TO);
`endif
        exp_acc   = !in_rng ? 0 : (tmo ? TO : waits + 1);
        exp_psel  = in_rng ? exp_acc + 1 : 0;
        exp_k     = in_rng ? exp_acc + 1 : 0;
        exp_err   = !in_rng || tmo || slverr;
        exp_rdata = (!exp_err && !wr) ? rdata : 32'd0;
        exp_bus   = {addr, wr, wr ? strb : 4'd0, wr ? wdata : 32'd0};

        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 12'($urandom);
        cmd_wdata = $urandom; cmd_strb = 4'($urandom);

        for (int k = 0; k < 80; k++) begin
            if (psel) begin
                psel_n++;
                check("apb_fields", {paddr, pwrite, pstrb, pwdata}, exp_bus);
            end else begin
                check("apb_idle_zero", {penable, paddr, pwrite, pstrb, pwdata}, 0);
            end
            if (rsp_valid) begin
                rsp_n++; rsp_k = k;
                got_rdata = rsp_rdata; got_err = rsp_err; got_to = rsp_timeout;
            end
            if (rsp_k >= 0 && k > rsp_k) begin
                check("cmd_ready_after", cmd_ready, 1);
                break;
            end
            check("cmd_ready_busy", cmd_ready, 0);
            if (psel && penable) begin
                pen_n++;
                pready  = (acc_idx == waits);
                pslverr = pready ? slverr : 1'($urandom);
                prdata  = pready ? rdata : $urandom;
                acc_idx++;
            end else begin
                pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
            end
            @(posedge clk); #1;
        end
        pready = 1'b0; pslverr = 1'b0;
        check("rsp_count", rsp_n, 1);
        check("rsp_latency", rsp_k, exp_k);
        check("psel_cycles", psel_n, exp_psel);
        check("penable_cycles", pen_n, exp_acc);
        check("rsp_err", got_err, exp_err);
        check("rsp_timeout", got_to, tmo);
        check("rsp_rdata", got_rdata, exp_rdata);
    endtask

    task automatic reset_mid_read();
        int seen = 0;
        check("cmd_ready_pre", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h004;
        @(posedge clk); #1;
        cmd_valid = 1'b0; pready = 1'b0;
        @(posedge clk); #1;
        check("reset_in_access", {psel, penable}, 2'b11);
        preset = 1'b1;
        @(posedge clk); #1;
        check("reset_drop_bus", {psel, penable, rsp_valid}, 0);
        check("reset_cmd_ready", cmd_ready, 1);
        preset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid || psel) seen++;
            @(posedge clk); #1;
        end
        check("reset_no_rsp", seen, 0);
        check("reset_ready_after", cmd_ready, 1);
    endtask

    initial begin
        preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 12'd0;
        cmd_wdata = 32'd0; cmd_strb = 4'd0; prdata = 32'd0; pready = 1'b0; pslverr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout, psel, penable}, 0);
        check("reset_bus", {pwrite, paddr, pstrb, pwdata}, 0);
        check("reset_cmd_ready", cmd_ready, 1);
        preset = 1'b0;
        @(posedge clk); #1;

        do_cmd(1'b1, 12'h008, 32'h15, 4'hF, 2, 1'b0, 32'h0);
        do_cmd(1'b0, 12'h004, 32'h0, 4'h0, 0, 1'b0, 32'hA5);
        do_cmd(1'b0, 12'h014, 32'h0, 4'h0, 0, 1'b0, 32'h0);
        do_cmd(1'b1, 12'h010, 32'hDEAD_BEEF, 4'h5, 1, 1'b1, 32'h0);
        do_cmd(1'b0, 12'h010, 32'h0, 4'h0, 0, 1'b1, 32'h1234_5678);
        do_cmd(1'b0, 12'h011, 32'h0, 4'h0, 0, 1'b0, 32'h0);
        do_cmd(1'b1, 12'h000, 32'h0000_00FF, 4'h1, 0, 1'b0, 32'h0);
        do_cmd(1'b0, 12'hFFF, 32'h0, 4'h0, 0, 1'b0, 32'h0);
`ifdef APB_TIMEOUT_EN
        do_cmd(1'b0, 12'h00C, 32'h0, 4'h0, TO - 1, 1'b0, 32'h0BAD_F00D);
        do_cmd(1'b0, 12'h00C, 32'h0, 4'h0, 40, 1'b0, 32'h0BAD_F00D);
        do_cmd(1'b1, 12'h004, 32'h77, 4'h3, 0, 1'b0, 32'h0);
`endif
        reset_mid_read();

        for (int t = 0; t < 40; t++) begin
            do_cmd(1'($urandom), 12'($urandom_range(0, 31)), $urandom, 4'($urandom),
                   int'($urandom_range(0, 4)), ($urandom_range(0, 7) == 0), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
